// File: rtl/load_store_unit.sv
// Memory-access stage: single-outstanding data-bus handshake with byte-lane steering,
// byte-enable generation, load extension, misalign detection and bus timeout.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [5:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [37:0] wb_reg,
  output logic        wb_valid,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam int          CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_we, w_we_nxt;
  logic [1:0]      r_size, w_size_nxt;
  logic            r_unsigned, w_unsigned_nxt;
  logic [1:0]      r_addr_lo, w_addr_lo_nxt;
  logic [5:0]      r_rd, w_rd_nxt;

  logic            w_ready_nxt, w_mem_req_nxt, w_mem_we_nxt;
  logic [31:0]     w_mem_addr_nxt, w_mem_wdata_nxt;
  logic [3:0]      w_mem_be_nxt;
  logic [37:0]     w_wb_reg_nxt;
  logic            w_wb_valid_nxt, w_done_nxt, w_err_nxt;

  logic            w_misaligned;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata_rep;
  logic [31:0]     w_shifted;
  logic [31:0]     w_load_data;

  // Request decode, evaluated on the live request fields at accept time.
  always_comb begin
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata_rep  = req_wdata;
    case (req_size)
      2'b00: begin
        w_be        = 4'b0001 << req_addr[1:0];
        w_wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_misaligned = req_addr[0];
        w_be         = 4'b0011 << req_addr[1:0];
        w_wdata_rep  = {2{req_wdata[15:0]}};
      end
      2'b10:   w_misaligned = (req_addr[1:0] != 2'b00);
      default: w_misaligned = 1'b1;
    endcase
  end

  // Load extraction uses the latched size/offset, since the request bus may have moved on.
  always_comb begin
    w_shifted   = mem_rdata >> {r_addr_lo, 3'b000};
    w_load_data = w_shifted;
    case (r_size)
      2'b00:   w_load_data = r_unsigned ? {24'd0, w_shifted[7:0]}
                                        : {{24{w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load_data = r_unsigned ? {16'd0, w_shifted[15:0]}
                                        : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_we_nxt        = r_we;
    w_size_nxt      = r_size;
    w_unsigned_nxt  = r_unsigned;
    w_addr_lo_nxt   = r_addr_lo;
    w_rd_nxt        = r_rd;
    w_ready_nxt     = req_ready;
    w_mem_req_nxt   = mem_req;
    w_mem_we_nxt    = mem_we;
    w_mem_addr_nxt  = mem_addr;
    w_mem_be_nxt    = mem_be;
    w_mem_wdata_nxt = mem_wdata;
    w_wb_reg_nxt    = wb_reg;
    w_wb_valid_nxt  = 1'b0;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;

    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_we_nxt       = req_we;
          w_size_nxt     = req_size;
          w_unsigned_nxt = req_unsigned;
          w_addr_lo_nxt  = req_addr[1:0];
          w_rd_nxt       = req_rd;
          w_ready_nxt    = 1'b0;
          if (w_misaligned) begin
            w_state_nxt = RESP;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt     = BUS;
            w_cnt_nxt       = '0;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = req_we;
            w_mem_addr_nxt  = {req_addr[31:2], 2'b00};
            w_mem_be_nxt    = w_be;
            w_mem_wdata_nxt = w_wdata_rep;
          end
        end
      end
      BUS: begin
        if (mem_ack || r_cnt == TO_LAST) begin
          w_state_nxt     = RESP;
          w_mem_req_nxt   = 1'b0;
          w_mem_we_nxt    = 1'b0;
          w_mem_be_nxt    = 4'b0000;
          w_mem_wdata_nxt = 32'd0;
          w_done_nxt      = 1'b1;
          // Ack beats a simultaneous timeout.
          w_err_nxt       = !mem_ack;
          if (mem_ack && !r_we && r_rd != 6'd0) begin
            w_wb_valid_nxt = 1'b1;
            w_wb_reg_nxt   = {r_rd, w_load_data};
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
        w_ready_nxt = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr_lo  <= 2'b00;
      r_rd       <= 6'd0;
      req_ready  <= 1'b1;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_be     <= 4'b0000;
      mem_wdata  <= 32'd0;
      wb_reg     <= 38'd0;
      wb_valid   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_we       <= w_we_nxt;
      r_size     <= w_size_nxt;
      r_unsigned <= w_unsigned_nxt;
      r_addr_lo  <= w_addr_lo_nxt;
      r_rd       <= w_rd_nxt;
      req_ready  <= w_ready_nxt;
      mem_req    <= w_mem_req_nxt;
      mem_we     <= w_mem_we_nxt;
      mem_addr   <= w_mem_addr_nxt;
      mem_be     <= w_mem_be_nxt;
      mem_wdata  <= w_mem_wdata_nxt;
      wb_reg     <= w_wb_reg_nxt;
      wb_valid   <= w_wb_valid_nxt;
      done       <= w_done_nxt;
      err        <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT=4), one task per scenario.
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [5:0]  req_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [37:0] wb_reg;
  logic        wb_valid;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  load_store_unit #(.TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_reg(wb_reg), .wb_valid(wb_valid), .done(done), .err(err)
  );

  always #5 i_clk = ~i_clk;

  // Observations gathered by run_op for the scenario tasks to judge.
  logic        o_ready_pre, o_ready_next, o_we, o_bus_bad;
  logic [3:0]  o_be;
  logic [31:0] o_wdata, o_addr;
  logic [37:0] o_wb_reg;
  int          o_req_cnt, o_done_cnt, o_err_cnt, o_wbv_cnt, o_done_lat;

  // Presents one request from a negedge, acks during the ack_cycle-th mem_req cycle (0 = never),
  // and returns at the negedge one cycle after done.
  task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [5:0] rd, input int ack_cycle, input logic [31:0] rdata);
    o_ready_pre = req_ready;
    o_ready_next = 1'b0; o_we = 1'b0; o_bus_bad = 1'b0;
    o_be = 4'h0; o_wdata = 32'h0; o_addr = 32'h0; o_wb_reg = wb_reg;
    o_req_cnt = 0; o_done_cnt = 0; o_err_cnt = 0; o_wbv_cnt = 0; o_done_lat = 0;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge i_clk);
      if (cyc == 1) req_valid = 1'b0;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      if (mem_req) begin
        o_req_cnt++;
        if (o_req_cnt == 1) begin
          o_be = mem_be; o_we = mem_we; o_wdata = mem_wdata; o_addr = mem_addr;
        end else if (mem_be !== o_be || mem_we !== o_we || mem_wdata !== o_wdata || mem_addr !== o_addr) begin
          o_bus_bad = 1'b1;
        end
        if (o_req_cnt == ack_cycle) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
      end else if (mem_we !== 1'b0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin
        o_bus_bad = 1'b1;
      end
      if (done) o_done_cnt++;
      if (err) o_err_cnt++;
      if (wb_valid) begin
        o_wbv_cnt++;
        o_wb_reg = wb_reg;
      end
      if (done && o_done_lat == 0) o_done_lat = cyc;
      if (o_done_lat != 0 && cyc == o_done_lat + 1) begin
        o_ready_next = req_ready;
        break;
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    total++; if ({mem_req, mem_we, mem_be} !== 6'b0) begin bad++; $display("FAIL reset_bus got=%b want=0", {mem_req, mem_we, mem_be}); end
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_addr_wdata got=%h/%h want=0/0", mem_addr, mem_wdata); end
    total++; if ({wb_valid, done, err} !== 3'b0 || wb_reg !== 38'h0) begin bad++; $display("FAIL reset_wb got=%b %h want=0 0", {wb_valid, done, err}, wb_reg); end
  endtask

  task automatic test_word_load();
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 6'd5, 3, 32'hDEAD_BEEF);
    total++; if (o_ready_pre !== 1'b1) begin bad++; $display("FAIL wl_ready_pre got=%b want=1", o_ready_pre); end
    total++; if (o_req_cnt != 3) begin bad++; $display("FAIL wl_req_cycles got=%0d want=3", o_req_cnt); end
    total++; if (o_be !== 4'b1111 || o_we !== 1'b0 || o_addr !== 32'h100) begin bad++; $display("FAIL wl_bus got=%b %b %h want=1111 0 100", o_be, o_we, o_addr); end
    total++; if (o_done_lat != 4) begin bad++; $display("FAIL wl_done_latency got=%0d want=4", o_done_lat); end
    total++; if (o_done_cnt != 1 || o_err_cnt != 0 || o_wbv_cnt != 1) begin bad++; $display("FAIL wl_pulses got=%0d/%0d/%0d want=1/0/1", o_done_cnt, o_err_cnt, o_wbv_cnt); end
    total++; if (o_wb_reg !== {6'd5, 32'hDEAD_BEEF}) begin bad++; $display("FAIL wl_wb_reg got=%h want=%h", o_wb_reg, {6'd5, 32'hDEAD_BEEF}); end
    total++; if (o_ready_next !== 1'b1) begin bad++; $display("FAIL wl_ready_back got=%b want=1", o_ready_next); end
    total++; if (o_bus_bad !== 1'b0) begin bad++; $display("FAIL wl_bus_hold got=%b want=0", o_bus_bad); end
  endtask

  task automatic test_sub_word_loads();
    run_op(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 6'd7, 1, 32'h8000_0000);
    total++; if (o_be !== 4'b1000) begin bad++; $display("FAIL lb_be got=%b want=1000", o_be); end
    total++; if (o_wbv_cnt != 1 || o_wb_reg !== {6'd7, 32'hFFFF_FF80}) begin bad++; $display("FAIL lb_signed got=%0d %h want=1 %h", o_wbv_cnt, o_wb_reg, {6'd7, 32'hFFFF_FF80}); end
    total++; if (o_done_lat != 2) begin bad++; $display("FAIL lb_done_latency got=%0d want=2", o_done_lat); end
    run_op(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 6'd8, 1, 32'h8000_0000);
    total++; if (o_wb_reg !== {6'd8, 32'h0000_0080}) begin bad++; $display("FAIL lbu_unsigned got=%h want=%h", o_wb_reg, {6'd8, 32'h0000_0080}); end
    run_op(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 6'd9, 2, 32'h8001_1234);
    total++; if (o_be !== 4'b1100) begin bad++; $display("FAIL lh_be got=%b want=1100", o_be); end
    total++; if (o_wb_reg !== {6'd9, 32'hFFFF_8001}) begin bad++; $display("FAIL lh_signed got=%h want=%h", o_wb_reg, {6'd9, 32'hFFFF_8001}); end
    run_op(1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0, 6'd10, 1, 32'h8001_F234);
    total++; if (o_wb_reg !== {6'd10, 32'h0000_F234}) begin bad++; $display("FAIL lhu_low got=%h want=%h", o_wb_reg, {6'd10, 32'h0000_F234}); end
  endtask

  task automatic test_stores();
    logic [37:0] prev;
    prev = wb_reg;
    run_op(1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h1234_5678, 6'd4, 2, 32'hFFFF_FFFF);
    total++; if (o_be !== 4'b0010 || o_we !== 1'b1) begin bad++; $display("FAIL sb_be_we got=%b %b want=0010 1", o_be, o_we); end
    total++; if (o_wdata !== 32'h7878_7878 || o_addr !== 32'h200) begin bad++; $display("FAIL sb_data_addr got=%h %h want=78787878 200", o_wdata, o_addr); end
    total++; if (o_done_cnt != 1 || o_wbv_cnt != 0 || o_err_cnt != 0) begin bad++; $display("FAIL sb_pulses got=%0d/%0d/%0d want=1/0/0", o_done_cnt, o_wbv_cnt, o_err_cnt); end
    total++; if (wb_reg !== prev) begin bad++; $display("FAIL sb_wb_hold got=%h want=%h", wb_reg, prev); end
    run_op(1'b1, 2'b01, 1'b0, 32'h0000_0302, 32'hAAAA_BEEF, 6'd4, 1, 32'h0);
    total++; if (o_be !== 4'b1100 || o_wdata !== 32'hBEEF_BEEF) begin bad++; $display("FAIL sh_be_data got=%b %h want=1100 beefbeef", o_be, o_wdata); end
    run_op(1'b1, 2'b10, 1'b0, 32'h0000_0304, 32'hCAFE_F00D, 6'd0, 1, 32'h0);
    total++; if (o_be !== 4'b1111 || o_wdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL sw_be_data got=%b %h want=1111 cafef00d", o_be, o_wdata); end
    total++; if (o_bus_bad !== 1'b0) begin bad++; $display("FAIL st_bus_idle_zero got=%b want=0", o_bus_bad); end
  endtask

  task automatic test_misaligned();
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 6'd5, 1, 32'h1111_1111);
    total++; if (o_req_cnt != 0) begin bad++; $display("FAIL mis_no_req got=%0d want=0", o_req_cnt); end
    total++; if (o_done_lat != 1 || o_err_cnt != 1 || o_done_cnt != 1) begin bad++; $display("FAIL mis_done_err got=%0d/%0d/%0d want=1/1/1", o_done_lat, o_err_cnt, o_done_cnt); end
    total++; if (o_wbv_cnt != 0 || o_ready_next !== 1'b1) begin bad++; $display("FAIL mis_wb_ready got=%0d %b want=0 1", o_wbv_cnt, o_ready_next); end
    run_op(1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h0, 6'd0, 1, 32'h0);
    total++; if (o_req_cnt != 0 || o_err_cnt != 1) begin bad++; $display("FAIL mis_half got=%0d/%0d want=0/1", o_req_cnt, o_err_cnt); end
    run_op(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 6'd3, 1, 32'h0);
    total++; if (o_req_cnt != 0 || o_err_cnt != 1 || o_wbv_cnt != 0) begin bad++; $display("FAIL mis_size11 got=%0d/%0d/%0d want=0/1/0", o_req_cnt, o_err_cnt, o_wbv_cnt); end
  endtask

  task automatic test_timeout();
    logic [37:0] prev;
    prev = wb_reg;
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 6'd6, 0, 32'h0);
    total++; if (o_req_cnt != 4) begin bad++; $display("FAIL to_req_cycles got=%0d want=4", o_req_cnt); end
    total++; if (o_done_lat != 5 || o_err_cnt != 1 || o_wbv_cnt != 0) begin bad++; $display("FAIL to_err got=%0d/%0d/%0d want=5/1/0", o_done_lat, o_err_cnt, o_wbv_cnt); end
    total++; if (wb_reg !== prev) begin bad++; $display("FAIL to_wb_hold got=%h want=%h", wb_reg, prev); end
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 6'd6, 4, 32'h5A5A_0001);
    total++; if (o_req_cnt != 4 || o_err_cnt != 0) begin bad++; $display("FAIL ack_at_limit got=%0d/%0d want=4/0", o_req_cnt, o_err_cnt); end
    total++; if (o_wbv_cnt != 1 || o_wb_reg !== {6'd6, 32'h5A5A_0001}) begin bad++; $display("FAIL ack_at_limit_wb got=%0d %h want=1 %h", o_wbv_cnt, o_wb_reg, {6'd6, 32'h5A5A_0001}); end
  endtask

  task automatic test_stray_ack();
    int n_done;
    n_done = 0;
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    repeat (4) begin
      @(negedge i_clk);
      if (done || wb_valid || mem_req) n_done++;
    end
    mem_ack = 1'b0;
    total++; if (n_done != 0 || req_ready !== 1'b1) begin bad++; $display("FAIL stray_ack got=%0d %b want=0 1", n_done, req_ready); end
  endtask

  task automatic test_reset_mid_bus();
    int n_evt;
    n_evt = 0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0000_0800; req_wdata = 32'h0; req_rd = 6'd9;
    @(negedge i_clk);
    req_valid = 1'b0;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_pre_req got=%b want=1", mem_req); end
    #2 i_rstn = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL rst_async got=%b %b want=0 1", mem_req, req_ready); end
    total++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || wb_reg !== 38'h0) begin bad++; $display("FAIL rst_async_vals got=%h %b %h want=0 0 0", mem_addr, mem_be, wb_reg); end
    @(negedge i_clk);
    i_rstn = 1'b1;
    mem_ack = 1'b1;
    repeat (4) begin
      @(negedge i_clk);
      if (done || wb_valid || err || mem_req) n_evt++;
    end
    mem_ack = 1'b0;
    total++; if (n_evt != 0) begin bad++; $display("FAIL rst_no_retire got=%0d want=0", n_evt); end
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 6'd3, 2, 32'h0BAD_F00D);
    total++; if (o_wbv_cnt != 1 || o_wb_reg !== {6'd3, 32'h0BAD_F00D}) begin bad++; $display("FAIL rst_after_load got=%0d %h want=1 %h", o_wbv_cnt, o_wb_reg, {6'd3, 32'h0BAD_F00D}); end
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_0504, 32'h0, 6'd0, 1, 32'h7777_7777);
    total++; if (o_done_cnt != 1 || o_wbv_cnt != 0 || o_err_cnt != 0) begin bad++; $display("FAIL rd0_load got=%0d/%0d/%0d want=1/0/0", o_done_cnt, o_wbv_cnt, o_err_cnt); end
    total++; if (wb_reg !== {6'd3, 32'h0BAD_F00D}) begin bad++; $display("FAIL rd0_wb_hold got=%h want=%h", wb_reg, {6'd3, 32'h0BAD_F00D}); end
  endtask

  initial begin
    i_rstn = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 6'd0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge i_clk);
    test_reset();
    i_rstn = 1'b1;
    @(negedge i_clk);
    test_word_load();
    test_sub_word_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_stray_ack();
    test_reset_mid_bus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "time limit");
  end

endmodule
